// File: rtl/in_port_reader.sv
// Memory-mapped 16-bit input port: synchronized, debounced pins with sticky edge flags and maskable irq.
// Latency: reads are combinational; pin change reaches stable at edge 2+DB_CYCLES; writes apply at the write edge.
// Backpressure: none; the CPU bus is always accepted and bus_out is 0 when not selected.
module in_port_reader #(
  parameter logic [15:0] DATA_ADDR = 16'h000A,
  parameter logic [15:0] EDGE_ADDR = 16'h000C,
  parameter logic [15:0] MASK_ADDR = 16'h000E,
  parameter int          DB_CYCLES = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] IO_pins,
  input  logic [15:0] adress,
  input  logic [15:0] bus_in,
  input  logic [1:0]  MemWrite,
  input  logic        MemRead,
  output logic [15:0] bus_out,
  output logic        irq
);

  // A single-cycle debounce still needs a one-bit counter so the array is never zero width.
  localparam int CW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);

  logic [15:0]   s1_q;
  logic [15:0]   sync_q;
  logic [15:0]   stable_q, stable_d;
  logic [15:0]   edge_flag_q, edge_flag_d;
  logic [15:0]   mask_q, mask_d;
  logic [CW-1:0] cnt_q [16];
  logic [CW-1:0] cnt_d [16];
  logic [15:0]   accept;
  logic          wr_en;
  logic          wr_edge;
  logic          wr_mask;

  assign wr_en   = |MemWrite;
  assign wr_edge = wr_en && (adress == EDGE_ADDR);
  assign wr_mask = wr_en && (adress == MASK_ADDR);

  // Per-bit debounce: count consecutive cycles where the synchronized pin disagrees with the accepted value.
  always_comb begin
    stable_d = stable_q;
    accept   = '0;
    for (int i = 0; i < 16; i++) begin
      cnt_d[i] = cnt_q[i];
      if (sync_q[i] == stable_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == CNT_LAST) begin
        stable_d[i] = sync_q[i];
        cnt_d[i]    = '0;
        accept[i]   = 1'b1;
      end else begin
        cnt_d[i] = cnt_q[i] + 1'b1;
      end
    end
  end

  // Sticky flags are cleared by write-1, but a same-cycle accept takes priority so no event is lost.
  always_comb begin
    edge_flag_d = edge_flag_q;
    if (wr_edge) begin
      edge_flag_d = edge_flag_d & ~bus_in;
    end
    edge_flag_d = edge_flag_d | accept;
    mask_d      = wr_mask ? bus_in : mask_q;
  end

  // All port state; reset discards any partial debounce count.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_q        <= '0;
      sync_q      <= '0;
      stable_q    <= '0;
      edge_flag_q <= '0;
      mask_q      <= '0;
      for (int i = 0; i < 16; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      s1_q        <= IO_pins;
      sync_q      <= s1_q;
      stable_q    <= stable_d;
      edge_flag_q <= edge_flag_d;
      mask_q      <= mask_d;
      for (int i = 0; i < 16; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  assign irq = |(edge_flag_q & mask_q);

  // Read mux; forced to 0 when not reading so it can be OR-merged onto the system bus.
  always_comb begin
    bus_out = '0;
    if (MemRead) begin
      if (adress == DATA_ADDR) begin
        bus_out = stable_q;
      end else if (adress == EDGE_ADDR) begin
        bus_out = edge_flag_q;
      end else if (adress == MASK_ADDR) begin
        bus_out = mask_q;
      end
    end
  end

endmodule

// File: doc/in_port_reader.md
# in_port_reader

Memory-mapped 16-bit input port, the read-side counterpart of the CPU's output port driver. It samples the external input pins through a two-flop synchronizer and debounces each bit. It latches change events into sticky edge flags and raises a maskable interrupt. The CPU reads pin state and flags, writes the mask, and clears flags over the same address/MemWrite bus used by the output port.

## Interface
Parameters:
- DATA_ADDR, 16'h000A: read-only debounced pin value register.
- EDGE_ADDR, 16'h000C: edge flag register; read, write-1-to-clear.
- MASK_ADDR, 16'h000E: interrupt mask register; read/write.
- DB_CYCLES, 4: consecutive stable cycles required to accept a pin change; legal range 1..255.

Ports:
- clk  in  1  clock; all state updates on its rising edge.
- reset  in  1  reset, synchronous, active-high.
- IO_pins  in  16  asynchronous external input pins.
- adress  in  16  CPU address.
- bus_in  in  16  CPU write data.
- MemWrite  in  2  write strobes; any bit set means a full 16-bit write.
- MemRead  in  1  read strobe.
- bus_out  out  16  read data; 0 when not selected.
- irq  out  1  interrupt request, level, active-high.

## Operation
- Synchronizer: s1 <= IO_pins, sync <= s1. Both are reset to 0.
- Debounce: each bit i has its own counter cnt[i] of width clog2(DB_CYCLES), minimum 1, plus a stable[i] bit.
  - If sync[i] == stable[i]: cnt[i] <= 0.
  - Else if cnt[i] == DB_CYCLES-1: stable[i] <= sync[i], cnt[i] <= 0. This is the accept event.
  - Else: cnt[i] <= cnt[i]+1.
  - A glitch shorter than DB_CYCLES sync cycles never reaches stable. When the glitch ends, the counter restarts from 0.
- Edge flags: edge[i] <= 1 on an accept event for bit i, for both rising and falling edges. The flag is sticky.
  - A write to EDGE_ADDR clears every bit where bus_in is 1.
  - If an accept and a clear hit the same bit in the same cycle, the set wins and the flag stays 1.
- Mask: a write to MASK_ADDR loads mask <= bus_in.
- irq = |(edge & mask). It is a combinational function of registered state, so it is glitch-free at the register outputs.
- Writes to DATA_ADDR or to any unmapped address are ignored. MemWrite with adress on a mapped register writes regardless of MemRead.
- Reads: when MemRead=1, bus_out is selected by adress.
  - DATA_ADDR returns stable.
  - EDGE_ADDR returns edge.
  - MASK_ADDR returns mask.
  - Otherwise bus_out is 0.
  - bus_out is 0 whenever MemRead=0, so it can be OR-merged onto the system read bus.
- Reset: s1, sync, stable, cnt, edge, mask all go to 0, so bus_out=0 and irq=0.
  - If a pin is held high through reset, it is accepted 2+DB_CYCLES edges after reset deasserts and sets its edge flag. This is intended and is not suppressed.
  - Reset asserted mid-debounce discards the partial count.

## Timing
- Reads: zero latency. bus_out is valid in the same cycle as MemRead/adress and reflects register values before that cycle's clock edge.
- Writes (mask, flag clear): take effect at the clock edge ending the write cycle. They are visible on reads and irq from the next cycle.
- Pin-to-stable latency: a pin change set up before edge 0 and held is captured by s1 at edge 1 and by sync at edge 2. stable updates and edge sets at edge 2+DB_CYCLES; with DB_CYCLES=4 that is edge 6.
- irq asserts in the cycle after the accepting edge if mask[i]=1. irq deasserts in the cycle after the clearing write, unless a new accept on a masked bit occurs at that same edge.
- Pins toggling every cycle never produce an accept for any DB_CYCLES >= 2.
- DB_CYCLES=1: a change is accepted at edge 3, the first edge where sync differs from stable.
- Bits are independent. Simultaneous accepts on several bits set all of their flags in the same edge.

## Test plan
- Reset with IO_pins=16'h0000, then drive 16'hA5A5 and hold (DB_CYCLES=4) -> DATA_ADDR read gives 0 through cycle 5 and 16'hA5A5 from cycle 6. EDGE_ADDR reads 16'hA5A5. irq stays 0 with mask=0.
- Write MASK_ADDR=16'h0001, then pulse bit 0 high for 3 sync cycles -> stable bit 0 never changes, edge=0, irq=0. Hold bit 0 high for 4+ cycles -> edge[0]=1 and irq=1 one cycle after the accept.
- With edge=16'h0081, write EDGE_ADDR bus_in=16'h0001 -> read edge=16'h0080, and irq drops next cycle when mask=16'h0001.
- Schedule a bit-0 accept on the same edge as an EDGE_ADDR write of 16'h0001 -> edge[0] remains 1 and irq stays high.
- MemRead=0 with adress=DATA_ADDR -> bus_out=0. MemRead=1 with adress=16'h0008 -> bus_out=0. A write to DATA_ADDR leaves the stable value unchanged.
- Assert reset mid-debounce with pins held at 16'hFFFF -> all registers 0 and irq=0. After release, DATA_ADDR=16'hFFFF at edge 6 and edge=16'hFFFF.
